// File: rtl/cei_mochila_pkg.sv
// ---------------------------------------------------------------------------
// cei_mochila_pkg
// System-level constants and helpers.
//   BANK_ARB_NMASTERS : masters sharing each RAM bank (core instr, core data,
//                       two external ports)
//   rr_pick()         : rotating-priority winner scan, up to 8 requesters
// ---------------------------------------------------------------------------
package cei_mochila_pkg;

    localparam int BANK_ARB_NMASTERS = 4;
    localparam int RR_MAX            = 8;

    // Returns {found, index}. Scans prio, prio+1, ... modulo n. The scan runs
    // from the farthest offset down so the nearest requester overwrites last.
    // prio < n and k < n, so a single conditional subtract gives the modulo.
    function automatic logic [3:0] rr_pick(input logic [7:0] req_vec,
                                           input logic [2:0] prio,
                                           input int         n);
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int k = RR_MAX - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = int'(prio) + k;
                if (idx >= n) idx = idx - n;
                if (req_vec[idx]) res = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/obi_pkg.sv
// ---------------------------------------------------------------------------
// obi_pkg
// OBI request/response bundle types shared by the bus crossbar, the bank
// arbiters and the memory banks.
//   obi_req_t  : req, we, be[3:0], addr[31:0], wdata[31:0]
//   obi_resp_t : gnt, rvalid, rdata[31:0]
// ---------------------------------------------------------------------------
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_id_fifo.sv
// ---------------------------------------------------------------------------
// obi_id_fifo
// Small FIFO of master IDs for in-flight bank transactions. Head is read
// combinationally so the response can be routed in the rvalid cycle.
// No overflow/underflow protection: the arbiter never pushes when full and
// never pops when empty.
//   clk, srst        : clock, synchronous active-high reset
//   push, push_id    : enqueue an ID
//   pop              : dequeue the head
//   count            : number of stored IDs
//   head             : oldest stored ID
// ---------------------------------------------------------------------------
module obi_id_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          push,
    input  logic [W-1:0]  push_id,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; stale entries are never visible past count.
    always_ff @(posedge clk) begin
        if (push) mem_reg[wr_ptr_reg] <= push_id;
    end

    assign count = count_reg;
    assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/obi_bank_arbiter.sv
// ---------------------------------------------------------------------------
// obi_bank_arbiter
// Round-robin arbiter sharing one RAM bank port among NMASTERS OBI masters.
// One request is granted per cycle; the granted master's ID is queued so each
// bank response is routed back to the master that issued it.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   master_req_i[]     : per-master OBI requests
//   master_resp_o[]    : per-master gnt / rvalid / rdata
//   slave_req_o        : request to the RAM bank
//   slave_resp_i       : bank gnt / rvalid / rdata
//   spurious_rvalid_o  : bank rvalid seen with no transaction outstanding
//   busy_o             : at least one transaction outstanding
// ---------------------------------------------------------------------------
module obi_bank_arbiter
    import obi_pkg::*;
    import cei_mochila_pkg::*;
#(
    parameter int NMASTERS  = BANK_ARB_NMASTERS,
    parameter int MAX_OUTST = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_req_t  master_req_i  [NMASTERS],
    output obi_resp_t master_resp_o [NMASTERS],
    output obi_req_t  slave_req_o,
    input  obi_resp_t slave_resp_i,
    output logic      spurious_rvalid_o,
    output logic      busy_o
);

    localparam int IDW = $clog2(NMASTERS);
    localparam int CW  = $clog2(MAX_OUTST + 1);

    logic [NMASTERS-1:0] req_vec;
    logic [IDW-1:0]      prio_q;
    logic [3:0]          pick;
    logic                any_req;
    logic [IDW-1:0]      winner;
    logic                issue;
    logic                accept;
    logic                pop;
    logic [CW-1:0]       count;
    logic [IDW-1:0]      head;
    logic                unused_pick_bits;

    generate
        for (genvar gi = 0; gi < NMASTERS; gi++) begin : g_req
            assign req_vec[gi] = master_req_i[gi].req;
        end
    endgenerate

    assign pick             = rr_pick(8'(req_vec), 3'(prio_q), NMASTERS);
    assign any_req          = pick[3];
    assign winner           = pick[IDW-1:0];
    assign unused_pick_bits = ^pick;

    // Full check uses the registered count: a same-cycle pop never frees a
    // slot early, so the ID FIFO cannot overflow.
    assign issue  = any_req && (count < CW'(MAX_OUTST)) && !rst_i;
    assign accept = issue && slave_resp_i.gnt;

    always_comb begin
        slave_req_o = '0;
        if (issue) begin
            slave_req_o     = master_req_i[winner];
            slave_req_o.req = 1'b1;
        end
    end

    // Responses follow issue order; an rvalid with nothing queued is dropped.
    assign pop               = slave_resp_i.rvalid && (count != '0) && !rst_i;
    assign spurious_rvalid_o = slave_resp_i.rvalid && (count == '0) && !rst_i;
    assign busy_o            = (count != '0) && !rst_i;

    generate
        for (genvar gi = 0; gi < NMASTERS; gi++) begin : g_resp
            logic rv_sel;
            assign rv_sel = pop && (head == IDW'(gi));
            assign master_resp_o[gi] = '{
                gnt:    accept && (winner == IDW'(gi)),
                rvalid: rv_sel,
                rdata:  rv_sel ? slave_resp_i.rdata : 32'h0
            };
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= '0;
        end else if (accept) begin
            prio_q <= (winner == IDW'(NMASTERS - 1)) ? '0 : winner + 1'b1;
        end
    end

    obi_id_fifo #(
        .DEPTH (MAX_OUTST),
        .W     (IDW)
    ) u_id_fifo (
        .clk     (clk_i),
        .srst    (rst_i),
        .push    (accept),
        .push_id (winner),
        .pop     (pop),
        .count   (count),
        .head    (head)
    );

endmodule

// File: tb/tb_obi_bank_arbiter.sv
module tb_obi_bank_arbiter;
    import obi_pkg::*;

    localparam int N  = 4;
    localparam int M  = 2;
    localparam int AW = 2 * N + N * 32 + $bits(obi_req_t) + 2;

    logic      clk = 1'b0;
    logic      rst_i;
    obi_req_t  mreq  [N];
    obi_resp_t mresp [N];
    obi_req_t  sreq;
    obi_resp_t sresp;
    logic      spur;
    logic      busy;

    always #5 clk = ~clk;

    obi_bank_arbiter #(.NMASTERS(N), .MAX_OUTST(M)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .master_req_i      (mreq),
        .master_resp_o     (mresp),
        .slave_req_o       (sreq),
        .slave_resp_i      (sresp),
        .spurious_rvalid_o (spur),
        .busy_o            (busy)
    );

    // reference model state: priority pointer and queue of outstanding IDs
    int prio_m;
    int idq [$];
    // bank model: in-order responses with due cycles
    int          cyc;
    int          bank_lat;
    logic        bank_gnt;
    logic        inject_rv;
    int          due_q [$];
    logic [31:0] dat_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [N-1:0]    e_gnt, e_rv, a_gnt, a_rv;
    logic [N*32-1:0] e_rdata, a_rdata;
    obi_req_t        e_sreq;
    logic            e_spur, e_busy;
    int              e_win;
    bit              e_acc, e_pop;
    logic [AW-1:0]   e_all, a_all;

    task automatic set_req(input int i, input logic [31:0] addr);
        mreq[i].req   = 1'b1;
        mreq[i].we    = 1'($urandom);
        mreq[i].be    = 4'($urandom);
        mreq[i].addr  = addr;
        mreq[i].wdata = $urandom;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) mreq[i] = '0;
    endtask

    task automatic drive_bank();
        logic due_now;
        due_now      = (due_q.size() > 0) && (due_q[0] == cyc);
        sresp.gnt    = bank_gnt;
        sresp.rvalid = inject_rv || due_now;
        sresp.rdata  = due_now ? dat_q[0] : $urandom;
    endtask

    // expected outputs from the rules: scan from prio, cap at M outstanding,
    // responses return to IDs in issue order
    task automatic model_eval();
        e_gnt = '0; e_rv = '0; e_rdata = '0; e_sreq = '0;
        e_spur = 1'b0; e_busy = 1'b0; e_win = -1; e_acc = 0; e_pop = 0;
        if (!rst_i) begin
            if (idq.size() < M) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (prio_m + k) % N;
                    if (e_win < 0 && mreq[c].req) e_win = c;
                end
            end
            if (e_win >= 0) begin
                e_sreq     = mreq[e_win];
                e_sreq.req = 1'b1;
                e_acc      = sresp.gnt;
                if (e_acc) e_gnt[e_win] = 1'b1;
            end
            e_busy = idq.size() > 0;
            if (sresp.rvalid) begin
                if (idq.size() > 0) begin
                    e_pop = 1;
                    e_rv[idq[0]] = 1'b1;
                    e_rdata[idq[0]*32 +: 32] = sresp.rdata;
                end else begin
                    e_spur = 1'b1;
                end
            end
        end
        e_all = {e_gnt, e_rv, e_rdata, e_sreq, e_spur, e_busy};
    endtask

    task automatic grab();
        for (int i = 0; i < N; i++) begin
            a_gnt[i] = mresp[i].gnt;
            a_rv[i]  = mresp[i].rvalid;
            a_rdata[i*32 +: 32] = mresp[i].rdata;
        end
        a_all = {a_gnt, a_rv, a_rdata, sreq, spur, busy};
    endtask

    task automatic step_prep();
        drive_bank();
        #1;
        model_eval();
        grab();
    endtask

    task automatic step_done();
        @(posedge clk);
        #1;
        if (rst_i) begin
            prio_m = 0;
            idq.delete();
        end else begin
            if (e_pop) void'(idq.pop_front());
            if (e_acc) begin
                idq.push_back(e_win);
                prio_m = (e_win + 1) % N;
            end
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
        end
        if (e_acc) begin
            int d;
            d = cyc + bank_lat;
            if (due_q.size() > 0 && due_q[$] >= d) d = due_q[$] + 1;
            due_q.push_back(d);
            dat_q.push_back($urandom);
            mreq[e_win].req = 1'b0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_reqs();
        inject_rv = 1'b0;
        bank_gnt  = 1'b0;
        repeat (2) begin
            step_prep();
            step_done();
        end
        rst_i = 1'b0;
        due_q.delete();
        dat_q.delete();
    endtask

    task automatic run_idle(input string name, input int n);
        clear_reqs();
        for (int k = 0; k < n; k++) begin
            step_prep();
            n_checks++;
            if (a_all !== e_all) $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, a_all, e_all);
            else n_pass++;
            step_done();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 32'h40 * i);
        bank_gnt  = 1'b1;
        inject_rv = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step_prep();
            n_checks++;
            if (a_all !== e_all) $display("FAIL reset cyc=%0d act=%h exp=%h", cyc, a_all, e_all);
            else n_pass++;
            $display("reset cyc=%0d gnt=%b rv=%b sreq=%0d spur=%0d busy=%0d", cyc, a_gnt, a_rv, sreq.req, spur, busy);
            step_done();
        end
        inject_rv = 1'b0;
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        bank_lat = 1; bank_gnt = 1'b1;
        set_req(2, 32'h100);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                set_req(0, 32'h200);
                set_req(3, 32'h300);
            end
            step_prep();
            n_checks++;
            if (a_all !== e_all) $display("FAIL single_model cyc=%0d act=%h exp=%h", cyc, a_all, e_all);
            else n_pass++;
            n_checks++;
            if ((k == 0 && (a_gnt !== 4'b0100 || sreq.addr !== 32'h100)) ||
                (k == 1 && (a_rv !== 4'b0100 || a_rdata[64 +: 32] !== sresp.rdata)) ||
                (k == 2 && busy !== 1'b0) ||
                (k == 3 && a_gnt !== 4'b1000))
                $display("FAIL single_step%0d gnt=%b rv=%b busy=%0d addr=%h", k, a_gnt, a_rv, busy, sreq.addr);
            else n_pass++;
            $display("single k=%0d gnt=%b rv=%b busy=%0d", k, a_gnt, a_rv, busy);
            step_done();
        end
        run_idle("single_drain", 4);
    endtask

    task automatic test_fairness();
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        bank_lat = 1; bank_gnt = 1'b1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) if (!mreq[i].req) set_req(i, 32'h1000 + 32'h10 * i);
            step_prep();
            n_checks++;
            if (a_all !== e_all) $display("FAIL fair_model cyc=%0d act=%h exp=%h", cyc, a_all, e_all);
            else n_pass++;
            n_checks++;
            if (a_gnt !== (4'b0001 << exp_order[k]))
                $display("FAIL fair_order k=%0d gnt=%b want master %0d", k, a_gnt, exp_order[k]);
            else n_pass++;
            $display("fair k=%0d gnt=%b rv=%b", k, a_gnt, a_rv);
            step_done();
        end
        run_idle("fair_drain", 4);
    endtask

    task automatic test_backpressure();
        do_reset();
        bank_lat = 1; bank_gnt = 1'b0;
        set_req(1, 32'h111);
        set_req(3, 32'h333);
        for (int k = 0; k < 5; k++) begin
            bank_gnt = (k >= 3);
            step_prep();
            n_checks++;
            if (a_all !== e_all) $display("FAIL bp_model cyc=%0d act=%h exp=%h", cyc, a_all, e_all);
            else n_pass++;
            n_checks++;
            if ((k < 3 && (sreq.addr !== 32'h111 || sreq.req !== 1'b1 || a_gnt !== 4'b0000)) ||
                (k == 3 && a_gnt !== 4'b0010) ||
                (k == 4 && a_gnt !== 4'b1000))
                $display("FAIL bp_step%0d gnt=%b addr=%h req=%0d", k, a_gnt, sreq.addr, sreq.req);
            else n_pass++;
            $display("bp k=%0d gnt=%b addr=%h", k, a_gnt, sreq.addr);
            step_done();
        end
        run_idle("bp_drain", 4);
    endtask

    task automatic test_full();
        int grants = 0;
        do_reset();
        bank_lat = 4; bank_gnt = 1'b1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) if (!mreq[i].req) set_req(i, 32'h2000 + 32'h10 * i);
            step_prep();
            n_checks++;
            if (a_all !== e_all) $display("FAIL full_model cyc=%0d act=%h exp=%h", cyc, a_all, e_all);
            else n_pass++;
            if (k < 4 && a_gnt != 0) grants++;
            if (k == 4) begin
                n_checks++;
                if (sreq.req !== 1'b0 || a_rv === 4'b0000) $display("FAIL full_pop_nogrant req=%0d rv=%b", sreq.req, a_rv);
                else n_pass++;
            end
            if (k == 5) begin
                n_checks++;
                if (a_gnt === 4'b0000) $display("FAIL full_regrant gnt=%b", a_gnt);
                else n_pass++;
            end
            $display("full k=%0d gnt=%b rv=%b req=%0d", k, a_gnt, a_rv, sreq.req);
            step_done();
        end
        n_checks++;
        if (grants !== 2) $display("FAIL full_grants got=%0d want=2", grants);
        else n_pass++;
        run_idle("full_drain", 10);
    endtask

    task automatic test_push_pop();
        do_reset();
        bank_lat = 1; bank_gnt = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (!mreq[0].req) set_req(0, 32'h3000 + 4 * k);
            step_prep();
            n_checks++;
            if (a_all !== e_all) $display("FAIL pp_model cyc=%0d act=%h exp=%h", cyc, a_all, e_all);
            else n_pass++;
            n_checks++;
            if (a_gnt !== 4'b0001 || (k > 0 && (busy !== 1'b1 || a_rv !== 4'b0001)))
                $display("FAIL pp_stream k=%0d gnt=%b rv=%b busy=%0d", k, a_gnt, a_rv, busy);
            else n_pass++;
            $display("pp k=%0d gnt=%b rv=%b busy=%0d", k, a_gnt, a_rv, busy);
            step_done();
        end
        run_idle("pp_drain", 4);
    endtask

    task automatic test_reset_midop();
        do_reset();
        bank_lat = 4; bank_gnt = 1'b1;
        set_req(0, 32'h4000);
        set_req(1, 32'h4010);
        set_req(2, 32'h4020);
        for (int k = 0; k < 6; k++) begin
            rst_i = (k == 2 || k == 3);
            if (k == 4) begin
                clear_reqs();
                while (due_q.size() > 1) begin
                    void'(due_q.pop_back());
                    void'(dat_q.pop_back());
                end
            end
            if (k == 5) begin
                set_req(0, 32'h4100);
                set_req(2, 32'h4120);
            end
            step_prep();
            n_checks++;
            if (a_all !== e_all) $display("FAIL rmid_model cyc=%0d act=%h exp=%h", cyc, a_all, e_all);
            else n_pass++;
            n_checks++;
            if (((k == 2 || k == 3) && (a_gnt !== 0 || a_rv !== 0 || sreq.req !== 0 || spur !== 0 || busy !== 0)) ||
                (k == 4 && (spur !== 1'b1 || a_rv !== 4'b0000)) ||
                (k == 5 && a_gnt !== 4'b0001))
                $display("FAIL rmid_step%0d gnt=%b rv=%b req=%0d spur=%0d busy=%0d", k, a_gnt, a_rv, sreq.req, spur, busy);
            else n_pass++;
            $display("rmid k=%0d gnt=%b rv=%b spur=%0d busy=%0d", k, a_gnt, a_rv, spur, busy);
            step_done();
        end
        rst_i = 1'b0;
        run_idle("rmid_drain", 6);
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bank_gnt = ($urandom % 4) != 0;
            bank_lat = 1 + ($urandom % 3);
            inject_rv = (idq.size() == 0) && (due_q.size() == 0) && (($urandom % 8) == 0);
            for (int i = 0; i < N; i++)
                if (!mreq[i].req && ($urandom % 10) < 4) set_req(i, $urandom & 32'hfffc);
            step_prep();
            n_checks++;
            if (a_all !== e_all) begin
                errs++;
                $display("FAIL random cyc=%0d act=%h exp=%h", cyc, a_all, e_all);
            end else n_pass++;
            step_done();
        end
        inject_rv = 1'b0;
        $display("random done errors=%0d", errs);
        run_idle("random_drain", 12);
    endtask

    initial begin
        rst_i = 1'b1; bank_gnt = 1'b0; inject_rv = 1'b0; bank_lat = 1;
        cyc = 0; prio_m = 0;
        clear_reqs();
        sresp = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_full();
        test_push_pop();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
